// File: rtl/dfso_pkg.sv
// dfso_pkg: control-byte fields and state encodings for diff_freq_serial_out_mc.
// Defining DFSO_REPEAT_EN turns on channel repeat mode.
package dfso_pkg;
  localparam int CTRL_CH_LSB = 0;
  localparam int CTRL_CH_W = 4;
  localparam int CTRL_RPT_BIT = 6;
  localparam int CTRL_STOP_BIT = 7;
`ifdef DFSO_REPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif
  typedef enum logic [1:0] {F_IDLE, F_DIV, F_DATA, F_DISPATCH} frame_state_e;
  typedef enum logic {CH_IDLE, CH_SHIFT} ch_state_e;
endpackage

// File: rtl/dfso_channel.sv
// dfso_channel: one serial channel, shifts a word MSB first at (div+1) clk cycles per bit.
module dfso_channel
  import dfso_pkg::*;
#(
  parameter int SW = 24,
  parameter int DW = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_repeat,
  input  logic [SW-1:0] i_word,
  input  logic [DW-1:0] i_div,
  output logic          o_serial,
  output logic          o_bit_tick,
  output logic          o_done_tick,
  output logic          o_busy
);
  localparam int BW = SW > 1 ? $clog2(SW) : 1;
  ch_state_e state_q, state_d;
  logic [SW-1:0] sr_q, sr_d, word_q, word_d;
  logic [DW-1:0] div_q, div_d, cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic rpt_q, rpt_d, bit_tick_q, bit_tick_d, done_q, done_d;
  logic period_end, last_bit, reload;
  always_comb begin
    period_end = cnt_q == div_q;
    last_bit = bit_q == BW'(SW-1);
    reload = rpt_q;
    state_d = state_q;
    sr_d = sr_q;
    word_d = word_q;
    div_d = div_q;
    rpt_d = rpt_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    bit_tick_d = 1'b0;
    done_d = 1'b0;
    if (i_abort) state_d = CH_IDLE;
    else if (state_q == CH_IDLE) begin
      if (i_start) begin
        state_d = CH_SHIFT;
        sr_d = i_word;
        word_d = i_word;
        div_d = i_div;
        rpt_d = i_repeat & REPEAT_EN;
        cnt_d = '0;
        bit_d = '0;
        bit_tick_d = 1'b1;
      end
    end else if (!period_end) cnt_d = cnt_q + 1'b1;
    else begin
      cnt_d = '0;
      bit_d = last_bit ? '0 : bit_q + 1'b1;
      sr_d = last_bit ? word_q : sr_q << 1;
      done_d = last_bit;
      bit_tick_d = !last_bit || reload;
      state_d = last_bit && !reload ? CH_IDLE : CH_SHIFT;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CH_IDLE;
      sr_q <= '0;
      word_q <= '0;
      div_q <= '0;
      rpt_q <= 1'b0;
      cnt_q <= '0;
      bit_q <= '0;
      bit_tick_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      word_q <= word_d;
      div_q <= div_d;
      rpt_q <= rpt_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      bit_tick_q <= bit_tick_d;
      done_q <= done_d;
    end
  end
  assign o_busy = state_q == CH_SHIFT;
  assign o_serial = o_busy ? sr_q[SW-1] : IDLE_LEVEL;
  assign o_bit_tick = bit_tick_q;
  assign o_done_tick = done_q;
endmodule

// File: rtl/diff_freq_serial_out_mc.sv
// diff_freq_serial_out_mc: decodes byte frames and dispatches words to independent serial channels.
// Repeat mode is compiled in with DFSO_REPEAT_EN.
module diff_freq_serial_out_mc
  import dfso_pkg::*;
#(
  parameter int CH_NUM = 4,
  parameter int DATA_BIT = 8,
  parameter int PAYLOAD_NUM = 3,
  parameter int TIMEOUT_CYC = 100000,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_BIT-1:0] i_data,
  input  logic                i_rx_done_tick,
  output logic [CH_NUM-1:0]   o_serial_out,
  output logic [CH_NUM-1:0]   o_bit_tick,
  output logic [CH_NUM-1:0]   o_done_tick,
  output logic [CH_NUM-1:0]   o_busy,
  output logic                o_frame_err
);
  localparam int SW = DATA_BIT * PAYLOAD_NUM;
  localparam int PW = $clog2(PAYLOAD_NUM + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  frame_state_e state_q, state_d;
  logic [CTRL_CH_W-1:0] ch_q, ch_d, c_ch;
  logic rpt_q, rpt_d, err_q, err_d, c_accept, c_stop;
  logic [DATA_BIT-1:0] div_q, div_d;
  logic [SW-1:0] word_q, word_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [CH_NUM-1:0] sel, start, abort;
  always_comb begin
    c_ch = i_data[CTRL_CH_LSB +: CTRL_CH_W];
    c_stop = i_data[CTRL_STOP_BIT];
    c_accept = i_rx_done_tick && (state_q == F_IDLE || state_q == F_DISPATCH);
    state_d = state_q;
    ch_d = ch_q;
    rpt_d = rpt_q;
    div_d = div_q;
    word_d = word_q;
    pcnt_d = pcnt_q;
    tmo_d = tmo_q;
    err_d = 1'b0;
    if (state_q == F_IDLE || state_q == F_DISPATCH) begin
      state_d = c_accept && !c_stop ? F_DIV : F_IDLE;
      ch_d = c_accept ? c_ch : ch_q;
      rpt_d = c_accept ? i_data[CTRL_RPT_BIT] : rpt_q;
      tmo_d = '0;
    end else if (i_rx_done_tick) begin
      tmo_d = '0;
      if (state_q == F_DIV) begin
        div_d = i_data;
        pcnt_d = '0;
        state_d = F_DATA;
      end else begin
        word_d = (word_q << DATA_BIT) | SW'(i_data);
        pcnt_d = pcnt_q + 1'b1;
        if (pcnt_q == PW'(PAYLOAD_NUM - 1)) begin
          state_d = F_DISPATCH;
          err_d = {1'b0, ch_q} >= 5'(CH_NUM) || |(o_busy & sel);
        end
      end
    end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
      state_d = F_IDLE;
      err_d = 1'b1;
    end else tmo_d = tmo_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= F_IDLE;
      ch_q <= '0;
      rpt_q <= 1'b0;
      div_q <= '0;
      word_q <= '0;
      pcnt_q <= '0;
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      rpt_q <= rpt_d;
      div_q <= div_d;
      word_q <= word_d;
      pcnt_q <= pcnt_d;
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign o_frame_err = err_q;
  // A frame flagged in error still passes through DISPATCH but starts nothing
  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    assign sel[i] = ch_q == CTRL_CH_W'(i);
    assign start[i] = state_q == F_DISPATCH && !err_q && sel[i];
    assign abort[i] = c_accept && c_stop && c_ch == CTRL_CH_W'(i);
    dfso_channel #(.SW(SW), .DW(DATA_BIT), .IDLE_LEVEL(IDLE_LEVEL)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .i_start    (start[i]),
      .i_abort    (abort[i]),
      .i_repeat   (rpt_q),
      .i_word     (word_q),
      .i_div      (div_q),
      .o_serial   (o_serial_out[i]),
      .o_bit_tick (o_bit_tick[i]),
      .o_done_tick(o_done_tick[i]),
      .o_busy     (o_busy[i])
    );
  end
endmodule

// File: tb/tb_diff_freq_serial_out_mc.sv
// tb_diff_freq_serial_out_mc: directed checks of framing, channel timing, errors and reset.
module tb_diff_freq_serial_out_mc;
  localparam int CH = 4;
  localparam int TO = 50;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] i_data = 8'h00;
  logic i_rx_done_tick = 1'b0;
  logic [CH-1:0] o_serial_out, o_bit_tick, o_done_tick, o_busy;
  logic o_frame_err;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  diff_freq_serial_out_mc #(
    .CH_NUM(CH), .DATA_BIT(8), .PAYLOAD_NUM(3), .TIMEOUT_CYC(TO), .IDLE_LEVEL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_rx_done_tick(i_rx_done_tick),
    .o_serial_out(o_serial_out), .o_bit_tick(o_bit_tick), .o_done_tick(o_done_tick),
    .o_busy(o_busy), .o_frame_err(o_frame_err)
  );
  task automatic step(input logic v, input logic [7:0] b);
    i_rx_done_tick = v;
    i_data = b;
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (o_serial_out !== 4'h0) begin errors++; $display("FAIL reset_serial got %h exp 0", o_serial_out); end
    checks++; if (o_bit_tick !== 4'h0) begin errors++; $display("FAIL reset_bit_tick got %h exp 0", o_bit_tick); end
    checks++; if (o_done_tick !== 4'h0) begin errors++; $display("FAIL reset_done got %h exp 0", o_done_tick); end
    checks++; if (o_busy !== 4'h0) begin errors++; $display("FAIL reset_busy got %h exp 0", o_busy); end
    checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", o_frame_err); end
    rst = 1'b0;
    step(0, 0);
  endtask
  task automatic test_single();
    logic [23:0] got = '0;
    int nt = 0, nb = 0;
    step(1, 8'h01); step(1, 8'h00); step(1, 8'hA5); step(1, 8'h0F); step(1, 8'h3C);
    checks++; if (o_busy[1] !== 1'b0) begin errors++; $display("FAIL single_busy_dispatch got %b exp 0", o_busy[1]); end
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      nt += int'(o_bit_tick[1]);
      nb += int'(!o_busy[1]);
      got = {got[22:0], o_serial_out[1]};
    end
    checks++; if (got !== 24'hA50F3C) begin errors++; $display("FAIL single_word got %h exp a50f3c", got); end
    checks++; if (nt != 24) begin errors++; $display("FAIL single_ticks got %0d exp 24", nt); end
    checks++; if (nb != 0) begin errors++; $display("FAIL single_busy_gaps got %0d exp 0", nb); end
    @(negedge clk);
    checks++; if (o_done_tick !== 4'b0010) begin errors++; $display("FAIL single_done got %b exp 0010", o_done_tick); end
    checks++; if (o_busy[1] !== 1'b0 || o_serial_out[1] !== 1'b0) begin errors++; $display("FAIL single_end got busy %b ser %b exp 0 0", o_busy[1], o_serial_out[1]); end
    step(0, 0);
  endtask
  task automatic test_two_freq();
    logic [7:0] fb [10] = '{8'h00, 8'h04, 8'h12, 8'h34, 8'h56, 8'h02, 8'h09, 8'hC3, 8'hA5, 8'h5A};
    int t0[$], t2[$];
    logic [23:0] w0 = '0, w2 = '0;
    int d0 = -1, d2 = -1, nd = 0, bad0 = 0, bad2 = 0, other = 0, nerr = 0;
    for (int c = 0; c < 260; c++) begin
      if (o_bit_tick[0]) begin t0.push_back(c); w0 = {w0[22:0], o_serial_out[0]}; end
      if (o_bit_tick[2]) begin t2.push_back(c); w2 = {w2[22:0], o_serial_out[2]}; end
      if (o_done_tick[0]) d0 = c;
      if (o_done_tick[2]) d2 = c;
      nd += int'(o_done_tick[0]) + int'(o_done_tick[2]);
      other += int'(o_bit_tick[1] | o_bit_tick[3]);
      nerr += int'(o_frame_err);
      if (c < 10) step(1, fb[c]); else step(0, 0);
    end
    for (int k = 1; k < t0.size(); k++) bad0 += int'(t0[k] - t0[k-1] != 5);
    for (int k = 1; k < t2.size(); k++) bad2 += int'(t2[k] - t2[k-1] != 10);
    checks++; if (t0.size() != 24 || t0[0] != 6) begin errors++; $display("FAIL two_ch0_ticks got n=%0d first=%0d exp 24 6", t0.size(), t0.size() ? t0[0] : -1); end
    checks++; if (t2.size() != 24 || t2[0] != 11) begin errors++; $display("FAIL two_ch2_ticks got n=%0d first=%0d exp 24 11", t2.size(), t2.size() ? t2[0] : -1); end
    checks++; if (bad0 != 0 || bad2 != 0) begin errors++; $display("FAIL two_periods got bad %0d %0d exp 0 0", bad0, bad2); end
    checks++; if (w0 !== 24'h123456) begin errors++; $display("FAIL two_ch0_word got %h exp 123456", w0); end
    checks++; if (w2 !== 24'hC3A55A) begin errors++; $display("FAIL two_ch2_word got %h exp c3a55a", w2); end
    checks++; if (d0 != 126 || d2 != 251 || nd != 2) begin errors++; $display("FAIL two_done got %0d %0d n=%0d exp 126 251 2", d0, d2, nd); end
    checks++; if (other != 0 || nerr != 0) begin errors++; $display("FAIL two_isolation got ticks %0d errs %0d exp 0 0", other, nerr); end
  endtask
  task automatic test_frame_err();
    logic [7:0] fe [15] = '{8'h00, 8'h20, 8'hF0, 8'hF0, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                           8'h07, 8'h00, 8'h11, 8'h22, 8'h33};
    int errc[$];
    int nt = 0, nd = 0, bad = 0;
    for (int c = 0; c < 76; c++) begin
      if (o_frame_err) errc.push_back(c);
      nt += int'(o_bit_tick[0]);
      nd += int'(o_done_tick[0]);
      if (c >= 6 && c <= 71) bad += int'(o_serial_out[0] !== 1'b1 || !o_busy[0]);
      if (c == 72) begin
        checks++; if (o_serial_out[0] !== 1'b0 || o_busy[0] !== 1'b0) begin errors++; $display("FAIL err_stop got ser %b busy %b exp 0 0", o_serial_out[0], o_busy[0]); end
      end
      if (c < 15) step(1, fe[c]); else if (c == 71) step(1, 8'h80); else step(0, 0);
    end
    checks++; if (errc.size() != 2 || errc[0] != 10 || errc[1] != 15) begin errors++; $display("FAIL err_pulses got n=%0d first=%0d exp 2 at 10 15", errc.size(), errc.size() ? errc[0] : -1); end
    checks++; if (nt != 2 || bad != 0) begin errors++; $display("FAIL err_ch0_undisturbed got ticks %0d bad %0d exp 2 0", nt, bad); end
    checks++; if (nd != 0) begin errors++; $display("FAIL err_no_done got %0d exp 0", nd); end
  endtask
  task automatic test_timeout();
    int errc[$], t3[$];
    logic [23:0] w3 = '0;
    int d3 = -1;
    for (int c = 0; c < 146; c++) begin
      if (o_frame_err) errc.push_back(c);
      if (o_bit_tick[3]) begin t3.push_back(c); w3 = {w3[22:0], o_serial_out[3]}; end
      if (o_done_tick[3]) d3 = c;
      if (c == 0 || c == 60) step(1, 8'h03);
      else if (c == 1 || c == 61 || c == 112) step(1, 8'h00);
      else if (c == 111) step(1, 8'h81);
      else if (c == 113) step(1, 8'h01);
      else step(0, 0);
    end
    checks++; if (errc.size() != 1 || errc[0] != 52) begin errors++; $display("FAIL timeout_err got n=%0d first=%0d exp 1 at 52", errc.size(), errc.size() ? errc[0] : -1); end
    checks++; if (t3.size() != 24 || t3[0] != 115) begin errors++; $display("FAIL timeout_restart got n=%0d first=%0d exp 24 115", t3.size(), t3.size() ? t3[0] : -1); end
    checks++; if (w3 !== 24'h810001 || d3 != 139) begin errors++; $display("FAIL timeout_word got %h done %0d exp 810001 139", w3, d3); end
  endtask
  task automatic test_repeat();
    logic [7:0] fr [5] = '{8'h40, 8'h00, 8'hC0, 8'h00, 8'h01};
    logic [23:0] w = 24'hC00001;
    int dc[$];
    int bad = 0;
    for (int c = 0; c < 71; c++) begin
      if (o_done_tick[0]) dc.push_back(c);
`ifdef DFSO_REPEAT_EN
      if (c >= 6 && c <= 60) bad += int'(o_serial_out[0] !== w[23 - ((c - 6) % 24)] || !o_busy[0]);
      if (c == 30) begin
        checks++; if (o_bit_tick[0] !== 1'b1) begin errors++; $display("FAIL repeat_reload_tick got %b exp 1", o_bit_tick[0]); end
      end
      if (c == 61) begin
        checks++; if (o_serial_out[0] !== 1'b0 || o_busy[0] !== 1'b0) begin errors++; $display("FAIL repeat_stop got ser %b busy %b exp 0 0", o_serial_out[0], o_busy[0]); end
      end
`else
      if (c >= 6 && c <= 29) bad += int'(o_serial_out[0] !== w[23 - (c - 6)] || !o_busy[0]);
      if (c == 31) begin
        checks++; if (o_busy[0] !== 1'b0 || o_bit_tick[0] !== 1'b0) begin errors++; $display("FAIL single_shot_end got busy %b tick %b exp 0 0", o_busy[0], o_bit_tick[0]); end
      end
`endif
      if (c < 5) step(1, fr[c]); else if (c == 60) step(1, 8'h80); else step(0, 0);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL repeat_bits got bad %0d exp 0", bad); end
`ifdef DFSO_REPEAT_EN
    checks++; if (dc.size() != 2 || dc[0] != 30 || dc[1] != 54) begin errors++; $display("FAIL repeat_done got n=%0d first=%0d exp 2 at 30 54", dc.size(), dc.size() ? dc[0] : -1); end
`else
    checks++; if (dc.size() != 1 || dc[0] != 30) begin errors++; $display("FAIL single_shot_done got n=%0d first=%0d exp 1 at 30", dc.size(), dc.size() ? dc[0] : -1); end
`endif
  endtask
  task automatic test_reset_mid();
    int ft = -1, nerr = 0, nd = 0;
    step(1, 8'h01); step(1, 8'h03); step(1, 8'hFF); step(1, 8'hFF); step(1, 8'hFF);
    repeat (20) step(0, 0);
    checks++; if (o_busy[1] !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b exp 1", o_busy[1]); end
    rst = 1'b1;
    step(0, 0);
    checks++; if (o_serial_out !== 4'h0 || o_busy !== 4'h0 || o_bit_tick !== 4'h0) begin errors++; $display("FAIL mid_reset_outputs got ser %h busy %h tick %h exp 0 0 0", o_serial_out, o_busy, o_bit_tick); end
    checks++; if (o_done_tick !== 4'h0 || o_frame_err !== 1'b0) begin errors++; $display("FAIL mid_reset_pulses got done %h err %b exp 0 0", o_done_tick, o_frame_err); end
    rst = 1'b0;
    step(1, 8'h02); step(1, 8'h00);
    rst = 1'b1;
    step(0, 0);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (o_bit_tick[2] && ft < 0) ft = c;
      nerr += int'(o_frame_err);
      nd += int'(|o_done_tick);
      if (c == 0) step(1, 8'h02); else if (c == 1) step(1, 8'h00);
      else if (c < 5) step(1, 8'hFF); else step(0, 0);
    end
    checks++; if (ft != 6 || nerr != 0 || nd != 0) begin errors++; $display("FAIL mid_frame_reset got tick %0d errs %0d done %0d exp 6 0 0", ft, nerr, nd); end
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_two_freq();
    test_frame_err();
    test_timeout();
    test_repeat();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
